// File: rtl/vga_palette_mixer.sv
// Final VGA colour stage: palette lookup, scanline darkening and palette banner overlay.
// Banner counter and swatch overlay are built only when PALETTE_MIXER_BANNER_EN is defined.
module vga_palette_mixer #(
   parameter int unsigned BANNER_FRAMES = 120,
   parameter int unsigned BANNER_X      = 64,
   parameter int unsigned BANNER_Y      = 48
) (
   input  logic       clkvga,
   input  logic       rst_n,
   input  logic       ce_2pix,
   input  logic       scanlines,
   input  logic [1:0] palette_sel,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic [3:0] v_in,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic [2:0] r_out,
   output logic [2:0] g_out,
   output logic [2:0] b_out,
   output logic       hs_out,
   output logic       vs_out
);

   // Stage 1
   logic [3:0] v_q;
   logic       hs1_q, vs1_q, dark_q;
   // Active palette
   logic [1:0] pal_q, pal_d;
   // Stage 2
   logic [2:0] r_q, g_q, b_q, r_d, g_d, b_d;
   logic       hs2_q, vs2_q;

   logic       vs_rise;
   logic [3:0] idx;
   logic [2:0] h;

`ifdef PALETTE_MIXER_BANNER_EN
   localparam logic [9:0] BannerX      = 10'(BANNER_X);
   localparam logic [9:0] BannerY      = 10'(BANNER_Y);
   localparam logic [7:0] BannerFrames = 8'(BANNER_FRAMES);

   logic [9:0] dx, dy;
   logic       in_banner_d, in_banner_q;
   logic [3:0] swatch_d, swatch_q;
   logic [7:0] cnt_q, cnt_d;

   // 10-bit wrapping subtraction keeps coordinates left of / above the banner out of range.
   always_comb begin
      dx          = pixel_x - BannerX;
      dy          = pixel_y - BannerY;
      in_banner_d = (dx < 10'd64) && (dy < 10'd16);
      swatch_d    = dx[5:2];
   end
`else
   logic unused_pix;
   assign unused_pix = ^{pixel_x, pixel_y[9:1]};
`endif

   // vs1_q holds vs_in from the previous enabled tick.
   assign vs_rise = vs_in & ~vs1_q;

   always_comb begin
      pal_d = pal_q;
`ifdef PALETTE_MIXER_BANNER_EN
      cnt_d = cnt_q;
`endif
      if (vs_rise) begin
         if (palette_sel != pal_q) begin
            pal_d = palette_sel;
`ifdef PALETTE_MIXER_BANNER_EN
            cnt_d = BannerFrames;
`endif
         end
`ifdef PALETTE_MIXER_BANNER_EN
         else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
         end
`endif
      end
   end

   always_comb begin
      idx = v_q;
`ifdef PALETTE_MIXER_BANNER_EN
      if (in_banner_q && (cnt_q != 8'd0)) idx = swatch_q;
`endif
      h = 3'(idx >> 1);
      r_d = h;
      g_d = h;
      b_d = h;
      unique case (pal_q)
         2'd0: ;
         2'd1: begin
            r_d = 3'd0;
            b_d = 3'd0;
         end
         2'd2: begin
            g_d = h >> 1;
            b_d = 3'd0;
         end
         2'd3: begin
            r_d = 3'd7 - h;
            g_d = 3'd7 - h;
            b_d = 3'd7 - h;
         end
      endcase
      if (dark_q) begin
         r_d = r_d >> 1;
         g_d = g_d >> 1;
         b_d = b_d >> 1;
      end
   end

   always_ff @(posedge clkvga or negedge rst_n) begin
      if (!rst_n) begin
         v_q         <= '0;
         hs1_q       <= 1'b0;
         vs1_q       <= 1'b0;
         dark_q      <= 1'b0;
         pal_q       <= '0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         hs2_q       <= 1'b0;
         vs2_q       <= 1'b0;
`ifdef PALETTE_MIXER_BANNER_EN
         in_banner_q <= 1'b0;
         swatch_q    <= '0;
         cnt_q       <= '0;
`endif
      end else if (ce_2pix) begin
         v_q         <= v_in;
         hs1_q       <= hs_in;
         vs1_q       <= vs_in;
         dark_q      <= scanlines & pixel_y[0];
         pal_q       <= pal_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
         hs2_q       <= hs1_q;
         vs2_q       <= vs1_q;
`ifdef PALETTE_MIXER_BANNER_EN
         in_banner_q <= in_banner_d;
         swatch_q    <= swatch_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign r_out  = r_q;
   assign g_out  = g_q;
   assign b_out  = b_q;
   assign hs_out = hs2_q;
   assign vs_out = vs2_q;

endmodule
